// File: rtl/uart_tx_mmio_responder.sv
// uart_tx_mmio_responder
// CPU-side register responder for the memory-mapped UART bus. Bytes written
// to the TX data register are queued in a small FIFO. A transmitter sends
// them 8N1 on tx_out and can raise an interrupt once the queue has drained.

module uart_tx_mmio_responder #(
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [3:0] addr,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    output logic       tx_out,
    output logic       irq,
    output logic [2:0] irq_id
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    txState_t      r_state;
    txState_t      w_nextState;

    logic          r_wrPrev;
    logic          r_rdPrev;
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_ctrl;
    logic [15:0]   r_divisor;
    logic          r_ovf;
    logic          r_irqPend;
    logic [7:0]    r_outData;
    logic [15:0]   r_bitCnt;
    logic [15:0]   r_bitDiv;
    logic [2:0]    r_bitIdx;
    logic [7:0]    r_shift;

    logic          w_wrAct;
    logic          w_rdAct;
    logic          w_wrEdge;
    logic          w_rdEdge;
    logic          w_empty;
    logic          w_full;
    logic          w_busy;
    logic          w_push;
    logic          w_pushOk;
    logic          w_drop;
    logic          w_pop;
    logic          w_bitDone;
    logic          w_stopToIdle;
    logic [15:0]   w_effDiv;
    logic [7:0]    w_status;
    logic [7:0]    w_readMux;
    logic          w_txOut;

    // A bus access is the first cycle a strobe is seen low with chip select;
    // a write occurring together with a read suppresses the read.
    assign w_wrAct  = !cs && !wr;
    assign w_rdAct  = !cs && !rd;
    assign w_wrEdge = w_wrAct && !r_wrPrev;
    assign w_rdEdge = w_rdAct && !r_rdPrev && !w_wrAct;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_busy   = (r_state != IDLE);

    // A push into a full FIFO still fits when the transmitter pops the same cycle.
    assign w_push   = w_wrEdge && (addr == 4'd0);
    assign w_pushOk = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && !w_pushOk;

    // Divisors below 2 are clamped so every bit lasts at least two clocks.
    assign w_effDiv  = (r_divisor < 16'd2) ? 16'd2 : r_divisor;
    assign w_bitDone = (r_bitCnt == 16'd0);

    assign w_stopToIdle = (r_state == STOP) && (w_nextState == IDLE);

    assign w_status = {3'b000, r_ovf, r_irqPend, w_empty, w_full, w_busy};

    // Remember the previous strobe levels so a held strobe acts only once.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPrev <= 1'b0;
            r_rdPrev <= 1'b0;
        end else begin
            r_wrPrev <= w_wrAct;
            r_rdPrev <= w_rdAct;
        end
    end

    // Register read multiplexer; unmapped addresses read as zero.
    always_comb begin
        w_readMux = 8'h00;
        case (addr)
            4'd1:    w_readMux = w_status;
            4'd2:    w_readMux = {6'b000000, r_ctrl};
            4'd3:    w_readMux = r_divisor[7:0];
            4'd4:    w_readMux = r_divisor[15:8];
            default: w_readMux = 8'h00;
        endcase
    end

    // Read data is captured on the read edge, held while rd stays low and
    // returns to zero as soon as rd is released.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_outData <= 8'h00;
        end else if (rd) begin
            r_outData <= 8'h00;
        end else if (w_rdEdge) begin
            r_outData <= w_readMux;
        end
    end

    // Control and divisor registers written from the bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ctrl    <= 2'b00;
            r_divisor <= DEFAULT_DIVISOR;
        end else if (w_wrEdge) begin
            case (addr)
                4'd2:    r_ctrl          <= in_data[1:0];
                4'd3:    r_divisor[7:0]  <= in_data;
                4'd4:    r_divisor[15:8] <= in_data;
                default: ;
            endcase
        end
    end

    // Sticky status flags. A status read clears them, but a new event in the
    // same cycle wins so it is never lost. The drain interrupt is only latched
    // while interrupts are enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf     <= 1'b0;
            r_irqPend <= 1'b0;
        end else begin
            if (w_rdEdge && (addr == 4'd1)) begin
                r_ovf     <= 1'b0;
                r_irqPend <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_stopToIdle && w_empty && r_ctrl[1]) begin
                r_irqPend <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the count defines validity.
    always_ff @(posedge clock) begin
        if (w_pushOk) begin
            r_fifo[r_wrPtr] <= in_data;
        end
    end

    // FIFO pointers wrap modulo the depth; the count is one bit wider so that
    // full and empty are distinguishable.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Transmitter state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Transmitter next-state logic. A byte is popped either from IDLE or
    // directly at the end of a stop bit, so consecutive frames have no gap.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ctrl[0] && !w_empty) begin
                    w_pop       = 1'b1;
                    w_nextState = START;
                end
            end
            START: begin
                if (w_bitDone) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_bitDone && (r_bitIdx == 3'd7)) begin
                    w_nextState = STOP;
                end
            end
            STOP: begin
                if (w_bitDone) begin
                    if (r_ctrl[0] && !w_empty) begin
                        w_pop       = 1'b1;
                        w_nextState = START;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Bit timing and shift register. The divisor is latched when a byte is
    // popped so a divisor write never disturbs a frame already in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bitCnt <= 16'd0;
            r_bitDiv <= 16'd2;
            r_bitIdx <= 3'd0;
            r_shift  <= 8'h00;
        end else if (w_pop) begin
            r_shift  <= r_fifo[r_rdPtr];
            r_bitDiv <= w_effDiv;
            r_bitCnt <= w_effDiv - 16'd1;
            r_bitIdx <= 3'd0;
        end else if (r_state != IDLE) begin
            if (w_bitDone) begin
                r_bitCnt <= r_bitDiv - 16'd1;
                if (r_state == DATA) begin
                    r_shift  <= {1'b0, r_shift[7:1]};
                    r_bitIdx <= r_bitIdx + 3'd1;
                end
            end else begin
                r_bitCnt <= r_bitCnt - 16'd1;
            end
        end
    end

    // Serial line level follows the state: low start bit, LSB-first data,
    // high stop bit and idle.
    always_comb begin
        w_txOut = 1'b1;
        case (r_state)
            START:   w_txOut = 1'b0;
            DATA:    w_txOut = r_shift[0];
            default: w_txOut = 1'b1;
        endcase
    end

    assign tx_out   = w_txOut;
    assign out_data = r_outData;
    assign irq      = r_irqPend && r_ctrl[1];
    assign irq_id   = irq ? 3'b001 : 3'b000;

endmodule
